cfg_loader: RTL and testbench
=============================

CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5: header byte that starts a configuration frame.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_data  input  8  configuration stream byte.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_ready  output  1  loader accepts a byte this cycle; transfer when in_valid && in_ready.
REQ-007 brbselect  output  900  routing-block config, stream bits 0..899.
REQ-008 bsbselect  output  1728  switch-block config, stream bits 900..2627.
REQ-009 lbselect  output  80  logic-block config, stream bits 2628..2707.
REQ-010 leftioselect  output  30  left IO config, stream bits 2708..2737.
REQ-011 rightioselect  output  30  right IO config, stream bits 2738..2767.
REQ-012 topioselect  output  30  top IO config, stream bits 2768..2797.
REQ-013 bottomioselect  output  30  bottom IO config, stream bits 2798..2827.
REQ-014 cfg_done  output  1  level; last frame committed.
REQ-015 cfg_err  output  1  level; last frame rejected on checksum.

Function
REQ-016 The frame SHALL be: SYNC_BYTE, 354 payload bytes, 1 checksum byte.
REQ-017 Payload byte n bit i SHALL map to stream bit 8n+i (LSB first); stream bits 2828..2831 (byte 353 bits 7:4) SHALL be discarded.
REQ-018 States SHALL be IDLE, LOAD, CSUM.
REQ-019 IDLE: accepted byte == SYNC_BYTE -> LOAD, byte counter 0, running checksum 0, cfg_done 0, cfg_err 0; any other byte SHALL be discarded with no state change.
REQ-020 LOAD: each accepted byte SHALL be written into a shadow register at its stream position and XORed into the checksum; acceptance of byte 353 -> CSUM.
REQ-021 In LOAD, a byte equal to SYNC_BYTE SHALL be treated as payload, not resync.
REQ-022 CSUM: accepted byte equal to the running checksum SHALL copy the shadow to all seven config outputs on that same edge and set cfg_done 1; mismatch SHALL set cfg_err 1 and leave outputs unchanged; both -> IDLE.
REQ-023 Config outputs SHALL change only at a CSUM commit edge; during LOAD they hold the previous configuration.
REQ-024 Commit latency: outputs and cfg_done visible in the cycle after the checksum byte transfer.
REQ-025 in_ready SHALL be 1 in every state after the first post-reset cycle; cycles with in_valid=0 SHALL not advance counter, checksum or state.
REQ-026 cfg_done/cfg_err SHALL hold until the next SYNC_BYTE is accepted in IDLE; never both 1.
REQ-027 Byte counter SHALL be 9 bits, never exceed 353, no wrap.

Reset
REQ-028 With rst=1 at an edge: state IDLE, counter 0, checksum 0, shadow 0, all config outputs 0, cfg_done 0, cfg_err 0, in_ready 0.
REQ-029 Reset mid-frame SHALL discard the partial frame; the next frame SHALL require a fresh SYNC_BYTE.
REQ-030 rst SHALL take priority over a simultaneous byte transfer.

Verification
REQ-031 Reset: assert rst 2 cycles -> all outputs 0, in_ready 0; cycle after release in_ready=1.
REQ-032 Hunt+load: send 0x00, 0xFF, 0xA5, payload byte0=0x10 rest 0x00, checksum 0x10 -> brbselect[4]=1, every other config bit 0, cfg_done=1 one cycle after checksum.
REQ-033 Bad checksum: after REQ-032 send frame byte0=0x01, checksum 0x00 -> cfg_err=1, cfg_done=0, brbselect[4] still 1, brbselect[0]=0.
REQ-034 Tail/padding: frame with byte 353=0xFF, rest 0x00, checksum 0xFF -> bottomioselect[29:26]=4'b1111, all other bits 0.
REQ-035 Embedded sync + gaps: payload byte 10=0xA5 with random in_valid gaps, correct checksum -> bsbselect unaffected, brbselect[87:80]=8'hA5, cfg_done=1.
REQ-036 Reset mid-load: rst after 100 payload bytes -> outputs 0, IDLE; following valid frame commits normally.

Source files
------------

// File: rtl/cfg_loader.sv
// rtl/cfg_loader.sv - framed configuration stream loader with XOR checksum and atomic commit
module cfg_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [899:0]  brbselect,
  output logic [1727:0] bsbselect,
  output logic [79:0]   lbselect,
  output logic [29:0]   leftioselect,
  output logic [29:0]   rightioselect,
  output logic [29:0]   topioselect,
  output logic [29:0]   bottomioselect,
  output logic          cfg_done,
  output logic          cfg_err
);

  typedef enum logic [1:0] {IDLE, LOAD, CSUM} state_t;

  localparam logic [8:0] LAST_BYTE = 9'd353;

  state_t        state, state_nxt;
  logic [8:0]    byte_cnt;
  logic [7:0]    csum;
  logic [2827:0] shadow;
  logic          ready_q;
  logic          xfer;

  assign in_ready = ready_q;
  assign xfer     = in_valid && ready_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (xfer && in_data == SYNC_BYTE) state_nxt = LOAD;
      LOAD:    if (xfer && byte_cnt == LAST_BYTE) state_nxt = CSUM;
      CSUM:    if (xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q        <= 1'b0;
      byte_cnt       <= '0;
      csum           <= '0;
      shadow         <= '0;
      brbselect      <= '0;
      bsbselect      <= '0;
      lbselect       <= '0;
      leftioselect   <= '0;
      rightioselect  <= '0;
      topioselect    <= '0;
      bottomioselect <= '0;
      cfg_done       <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (xfer) begin
        unique case (state)
          IDLE: begin
            if (in_data == SYNC_BYTE) begin
              byte_cnt <= '0;
              csum     <= '0;
              cfg_done <= 1'b0;
              cfg_err  <= 1'b0;
            end
          end
          LOAD: begin
            // Last payload byte only carries 4 real bits; the upper nibble still feeds the checksum.
            if (byte_cnt == LAST_BYTE) begin
              shadow[2827:2824] <= in_data[3:0];
            end else begin
              shadow[{byte_cnt, 3'b000} +: 8] <= in_data;
              byte_cnt <= byte_cnt + 9'd1;
            end
            csum <= csum ^ in_data;
          end
          CSUM: begin
            if (in_data == csum) begin
              brbselect      <= shadow[899:0];
              bsbselect      <= shadow[2627:900];
              lbselect       <= shadow[2707:2628];
              leftioselect   <= shadow[2737:2708];
              rightioselect  <= shadow[2767:2738];
              topioselect    <= shadow[2797:2768];
              bottomioselect <= shadow[2827:2798];
              cfg_done       <= 1'b1;
            end else begin
              cfg_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
// tb/tb_cfg_loader.sv - randomized self-checking bench for cfg_loader against a frame-level model
module tb_cfg_loader;

  localparam logic [7:0] SYNC = 8'hA5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [899:0]  brbselect;
  logic [1727:0] bsbselect;
  logic [79:0]   lbselect;
  logic [29:0]   leftioselect, rightioselect, topioselect, bottomioselect;
  logic          cfg_done, cfg_err;

  cfg_loader #(.SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .brbselect(brbselect), .bsbselect(bsbselect), .lbselect(lbselect),
    .leftioselect(leftioselect), .rightioselect(rightioselect),
    .topioselect(topioselect), .bottomioselect(bottomioselect),
    .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Frame-level model: the committed configuration as one stream vector plus status levels.
  logic [2827:0] exp_cfg = '0;
  logic          exp_done = 1'b0, exp_err = 1'b0, exp_ready = 1'b0;
  logic          cmp_en = 1'b0;
  logic [7:0]    pl [354];
  int            vectors = 0;
  int            fails = 0;

  function automatic logic [2827:0] pack_payload();
    logic [2827:0] v = '0;
    for (int n = 0; n < 354; n++)
      for (int i = 0; i < 8; i++)
        if (8 * n + i < 2828) v[8 * n + i] = pl[n][i];
    return v;
  endfunction

  function automatic logic [7:0] xor_payload();
    logic [7:0] x = 8'h00;
    for (int n = 0; n < 354; n++) x = x ^ pl[n];
    return x;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      vectors++;
      if (brbselect !== exp_cfg[899:0]) begin
        fails++; $display("FAIL brbselect: %0d bits differ", $countones(brbselect ^ exp_cfg[899:0]));
      end
      if (bsbselect !== exp_cfg[2627:900]) begin
        fails++; $display("FAIL bsbselect: %0d bits differ", $countones(bsbselect ^ exp_cfg[2627:900]));
      end
      if (lbselect !== exp_cfg[2707:2628]) begin
        fails++; $display("FAIL lbselect: got %h want %h", lbselect, exp_cfg[2707:2628]);
      end
      if ({bottomioselect, topioselect, rightioselect, leftioselect} !== exp_cfg[2827:2708]) begin
        fails++; $display("FAIL ioselect: got %h want %h",
                          {bottomioselect, topioselect, rightioselect, leftioselect}, exp_cfg[2827:2708]);
      end
      if (cfg_done !== exp_done || cfg_err !== exp_err || in_ready !== exp_ready) begin
        fails++; $display("FAIL status: got done=%b err=%b ready=%b want done=%b err=%b ready=%b",
                          cfg_done, cfg_err, in_ready, exp_done, exp_err, exp_ready);
      end
    end
  end

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = SYNC;
    repeat (cycles) begin
      @(posedge clk); #1;
      exp_cfg = '0; exp_done = 1'b0; exp_err = 1'b0; exp_ready = 1'b0;
      cmp_en = 1'b1;
    end
    lit("ready_in_reset", 64'(in_ready), 64'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    exp_ready = 1'b1;
    lit("ready_after_reset", 64'(in_ready), 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int gaps = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    repeat (gaps) begin
      in_valid = 1'b0;
      in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_sync(input int gap_max);
    send_byte(SYNC, gap_max);
    exp_done = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] ck, input int gap_max);
    send_sync(gap_max);
    for (int n = 0; n < 354; n++) send_byte(pl[n], gap_max);
    send_byte(ck, gap_max);
    if (ck == xor_payload()) begin
      exp_cfg = pack_payload();
      exp_done = 1'b1;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic clear_payload();
    for (int n = 0; n < 354; n++) pl[n] = 8'h00;
  endtask

  task automatic random_payload();
    for (int n = 0; n < 354; n++) pl[n] = 8'($urandom_range(0, 255));
  endtask

  task automatic send_garbage(input int count);
    logic [7:0] g;
    for (int k = 0; k < count; k++) begin
      g = 8'($urandom_range(0, 255));
      if (g == SYNC) g = 8'h5A;
      send_byte(g, 1);
    end
  endtask

  initial begin
    do_reset(2);

    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    clear_payload();
    pl[0] = 8'h10;
    lit("model_pack_bit4", 64'(pack_payload() == 2828'h10), 64'd1);
    lit("model_xor", 64'(xor_payload()), 64'h10);
    send_frame(8'h10, 0);
    lit("hunt_brb_low", 64'(brbselect[63:0]), 64'h10);
    lit("hunt_done", 64'({cfg_done, cfg_err}), 64'b10);

    clear_payload();
    pl[0] = 8'h01;
    send_frame(8'h00, 0);
    lit("bad_ck_status", 64'({cfg_done, cfg_err}), 64'b01);
    lit("bad_ck_brb_low", 64'(brbselect[7:0]), 64'h10);

    clear_payload();
    pl[353] = 8'hFF;
    send_frame(8'hFF, 0);
    lit("tail_bottomio", 64'(bottomioselect), 64'h3C00_0000);
    lit("tail_top_right", 64'({topioselect, rightioselect}), 64'd0);

    clear_payload();
    pl[10] = SYNC;
    send_frame(SYNC, 3);
    lit("sync_payload_brb", 64'(brbselect[87:80]), 64'hA5);
    lit("sync_payload_done", 64'(cfg_done), 64'd1);

    random_payload();
    send_sync(1);
    for (int n = 0; n < 100; n++) send_byte(pl[n], 1);
    do_reset(1);
    lit("midreset_brb", 64'(brbselect[63:0]), 64'd0);
    send_garbage(6);
    send_frame(xor_payload(), 2);

    for (int f = 0; f < 10; f++) begin
      random_payload();
      send_garbage($urandom_range(0, 3));
      if (f % 3 == 2) send_frame(xor_payload() ^ 8'($urandom_range(1, 255)), 2);
      else            send_frame(xor_payload(), 2);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
